i2s_dac_tx: RTL and testbench

Audio output end of the synth voice datapath. Accepts the 32-bit mixed, saturated TONE word once per audio frame through a valid/ready handshake. Scales and saturates it to the codec word width, then serializes it as mono I2S (same word on left and right slots) toward the board codec DAC. Generates BCLK and LRCLK from CLK and pulses SAMPLE_REQ at each frame start, so the voice-iteration controller knows to begin accumulating the next sample.

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_sat_scale.sv | 27 ++
 rtl/i2s_dac_tx.sv | 127 ++++++++++++
 tb/tb_i2s_dac_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and saturation-limit helpers for the I2S DAC transmitter
package i2s_pkg;

  localparam int CLK_DIV_D     = 8;
  localparam int SLOT_BITS_D   = 32;
  localparam int WORD_W_D      = 24;
  localparam int SCALE_SHIFT_D = 8;
  localparam int FRAME_BITS_D  = 2 * SLOT_BITS_D;

  // Limits are 33 bits wide so WORD_W = 32 still has headroom for the comparison.
  function automatic logic signed [32:0] sat_max(input int w);
    return (33'sd1 <<< (w - 1)) - 33'sd1;
  endfunction

  function automatic logic signed [32:0] sat_min(input int w);
    return -(33'sd1 <<< (w - 1));
  endfunction

  localparam logic signed [32:0] SAT_MAX_D = sat_max(WORD_W_D);
  localparam logic signed [32:0] SAT_MIN_D = sat_min(WORD_W_D);

endpackage

// File: rtl/i2s_sat_scale.sv
// rtl/i2s_sat_scale.sv - arithmetic shift of the mixed sample and saturation to the DAC word width
module i2s_sat_scale
  import i2s_pkg::*;
#(
  parameter int WORD_W      = WORD_W_D,
  parameter int SCALE_SHIFT = SCALE_SHIFT_D
) (
  input  logic [31:0]       sample,
  output logic [WORD_W-1:0] word
);

  localparam logic signed [32:0] HI = sat_max(WORD_W);
  localparam logic signed [32:0] LO = sat_min(WORD_W);

  logic signed [32:0] s;

  always_comb begin
    s = $signed({sample[31], sample}) >>> SCALE_SHIFT;
    if (s > HI)
      word = HI[WORD_W-1:0];
    else if (s < LO)
      word = LO[WORD_W-1:0];
    else
      word = s[WORD_W-1:0];
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - mono I2S transmitter with BCLK/LRCLK generation and one-word holding register
// Optional: I2S_UNDERRUN_MUTE_EN sends a silent frame on underrun instead of repeating the last word.
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_D,
  parameter int SLOT_BITS   = SLOT_BITS_D,
  parameter int WORD_W      = WORD_W_D,
  parameter int SCALE_SHIFT = SCALE_SHIFT_D
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] SAMPLE_IN,
  input  logic        SAMPLE_VALID,
  output logic        SAMPLE_READY,
  output logic        SAMPLE_REQ,
  output logic        UNDERRUN,
  output logic        BCLK,
  output logic        LRCLK,
  output logic        DACDAT
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int BW    = $clog2(FRAME);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(FRAME - 1);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_BITS);
  localparam logic [BW-1:0] LR_LO    = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] LR_HI    = BW'(FRAME - 2);
  localparam logic [BW-1:0] WORD_B   = BW'(WORD_W);

  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [WORD_W-1:0] out_word;
  logic [WORD_W-1:0] hold;
  logic              hold_full;
  logic [WORD_W-1:0] sat_word;

  logic              div_wrap;
  logic              fall;
  logic              load;
  logic [BW-1:0]     b_next;
  logic [BW-1:0]     p;
  logic [WORD_W-1:0] word_next;
  logic [WORD_W-1:0] word_shift;
  logic              dat_next;
  logic              lr_next;

  i2s_sat_scale #(
    .WORD_W      (WORD_W),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_sat (
    .sample (SAMPLE_IN),
    .word   (sat_word)
  );

  assign SAMPLE_READY = !hold_full;

  // Everything serial is computed for the new bit index b so it lands on the falling BCLK edge.
  always_comb begin
    div_wrap = (div_cnt == DIV_LAST);
    fall     = div_wrap && BCLK;
    b_next   = (bit_cnt == B_LAST) ? '0 : bit_cnt + 1'b1;
    p        = (b_next >= SLOT_B) ? b_next - SLOT_B : b_next;
    load     = fall && (b_next == '0);
    lr_next  = (b_next >= LR_LO) && (b_next <= LR_HI);

    word_next = out_word;
    if (load) begin
      if (hold_full)
        word_next = hold;
      else begin
`ifdef I2S_UNDERRUN_MUTE_EN
        word_next = '0;
`else
        word_next = out_word;
`endif
      end
    end

    word_shift = word_next << p;
    dat_next   = (p < WORD_B) ? word_shift[WORD_W-1] : 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt    <= '0;
      bit_cnt    <= B_LAST;
      out_word   <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      BCLK       <= 1'b0;
      LRCLK      <= 1'b0;
      DACDAT     <= 1'b0;
      SAMPLE_REQ <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else begin
      SAMPLE_REQ <= 1'b0;
      UNDERRUN   <= 1'b0;
      div_cnt    <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap)
        BCLK <= ~BCLK;

      if (fall) begin
        bit_cnt  <= b_next;
        LRCLK    <= lr_next;
        DACDAT   <= dat_next;
        out_word <= word_next;
      end

      if (load) begin
        SAMPLE_REQ <= 1'b1;
        UNDERRUN   <= !hold_full;
        hold_full  <= 1'b0;
      end

      // A capture in the load cycle with hold empty is kept for the following frame.
      if (SAMPLE_VALID && !hold_full) begin
        hold      <= sat_word;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - directed self-checking bench for i2s_dac_tx (default parameters)
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_req;
  logic        underrun;
  logic        bclk;
  logic        lrclk;
  logic        dacdat;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int und_cnt = 0;
  int n_xfer = 0;
  logic prev_bclk = 1'b0;
  logic fell = 1'b0;

  localparam logic [63:0] LR_EXP = 64'h7FFF_FFFF_8000_0000;
`ifdef I2S_UNDERRUN_MUTE_EN
  localparam logic [23:0] UR_WORD = 24'h000000;
`else
  localparam logic [23:0] UR_WORD = 24'h001234;
`endif

  i2s_dac_tx dut (
    .CLK          (clk),
    .RESET        (reset),
    .SAMPLE_IN    (sample_in),
    .SAMPLE_VALID (sample_valid),
    .SAMPLE_READY (sample_ready),
    .SAMPLE_REQ   (sample_req),
    .UNDERRUN     (underrun),
    .BCLK         (bclk),
    .LRCLK        (lrclk),
    .DACDAT       (dacdat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; the source drops VALID after a completed transfer.
  task automatic step();
    logic x;
    x = sample_valid && sample_ready;
    prev_bclk = bclk;
    @(posedge clk);
    #1;
    fell = prev_bclk && !bclk;
    if (sample_req) req_cnt++;
    if (underrun) und_cnt++;
    if (x) begin
      sample_valid = 1'b0;
      n_xfer++;
    end
  endtask

  task automatic next_fall(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!fell && n < 40);
    if (!fell) chk("bclk_fall_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] exp_frame(input logic [23:0] w);
    logic [63:0] r;
    int p;
    r = '0;
    for (int b = 0; b < 64; b++) begin
      p = b % 32;
      if (p < 24) r[b] = w[23-p];
    end
    return r;
  endfunction

  task automatic check_frame(input string tag, input logic [23:0] w, input int und,
                             output logic rdy0, output int first_n);
    logic [63:0] dat;
    logic [63:0] lr;
    int n;
    req_cnt = 0;
    und_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      next_fall(n);
      if (i == 0) begin
        first_n = n;
        rdy0 = sample_ready;
      end
      dat[i] = dacdat;
      lr[i]  = lrclk;
    end
    chk({tag, "_dacdat"}, dat, exp_frame(w));
    chk({tag, "_lrclk"}, lr, LR_EXP);
    chk({tag, "_req_pulses"}, req_cnt, 1);
    chk({tag, "_underrun_pulses"}, und_cnt, und);
  endtask

  task automatic load(input logic [31:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    step();
  endtask

  initial begin
    logic rdy0;
    int n;
    int x0;
    logic hi;

    reset = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    repeat (3) step();
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_dacdat", dacdat, 0);
    chk("rst_req", sample_req, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", sample_ready, 1);

    reset = 1'b0;
    hi = 1'b0;
    repeat (7) begin
      step();
      hi = hi | bclk;
    end
    chk("bclk_low_7", hi, 0);
    step();
    chk("bclk_rise_8", bclk, 1);
    check_frame("idle", 24'h000000, 1, rdy0, n);
    chk("idle_first_fall", n, 8);
    chk("idle_ready", rdy0, 1);

    load(32'h1234_5600);
    chk("load_ready_low", sample_ready, 0);
    check_frame("w123456", 24'h123456, 0, rdy0, n);
    chk("w123456_latency", n, 15);
    chk("w123456_ready", rdy0, 1);

    load(32'h7FFF_FFFF);
    check_frame("sat_pos", 24'h7FFFFF, 0, rdy0, n);
    load(32'h8000_0000);
    check_frame("sat_neg", 24'h800000, 0, rdy0, n);
    load(32'hFFFF_FF00);
    check_frame("minus_one", 24'hFFFFFF, 0, rdy0, n);

    load(32'h00AB_CD00);
    sample_in = 32'h0012_3400;
    sample_valid = 1'b1;
    x0 = n_xfer;
    repeat (3) step();
    chk("full_ready", sample_ready, 0);
    chk("full_not_taken", n_xfer, x0);
    check_frame("wabcd", 24'h00ABCD, 0, rdy0, n);
    chk("wabcd_ready_at_load", rdy0, 1);
    chk("held_taken", n_xfer, x0 + 1);
    chk("held_ready_low", sample_ready, 0);
    check_frame("w1234", 24'h001234, 0, rdy0, n);

    repeat (15) step();
    sample_in = 32'h0000_0100;
    sample_valid = 1'b1;
    check_frame("underrun", UR_WORD, 1, rdy0, n);
    chk("underrun_load_cycle", n, 1);
    chk("underrun_captured", rdy0, 0);
    check_frame("after_underrun", 24'h000001, 0, rdy0, n);

    repeat (40) next_fall(n);
    chk("mid_right_lrclk", lrclk, 1);
    load(32'h0055_5500);
    chk("mid_ready_low", sample_ready, 0);
    reset = 1'b1;
    step();
    chk("midrst_bclk", bclk, 0);
    chk("midrst_lrclk", lrclk, 0);
    chk("midrst_dacdat", dacdat, 0);
    chk("midrst_ready", sample_ready, 1);
    reset = 1'b0;
    check_frame("post_reset", 24'h000000, 1, rdy0, n);
    chk("post_reset_first_fall", n, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
